// File: rtl/irq_controller_prio.sv
// rtl/irq_controller_prio.sv - priority interrupt controller with claim/complete handshake
// Optional IRQ_THRESHOLD_EN adds a priority threshold register (thr_we/thr_wdata).
module irq_controller_prio #(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W = 3,
  parameter int XLEN = 64,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = 8'h0F,
  localparam int ID_W = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               en_we,
  input  logic [NUM_SRC-1:0] en_wdata,
  input  logic               prio_we,
  input  logic [ID_W-1:0]    prio_idx,
  input  logic [PRIO_W-1:0]  prio_wdata,
  input  logic [XLEN-1:0]    pc_in,
  input  logic               irq_ack,
  input  logic               irq_done,
  input  logic [ID_W-1:0]    done_id,
`ifdef IRQ_THRESHOLD_EN
  input  logic               thr_we,
  input  logic [PRIO_W-1:0]  thr_wdata,
`endif
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  output logic [XLEN-1:0]    pc_save,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending_out
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t              state_q, state_d;
  logic [NUM_SRC-1:0]  pending, prev, enable, elig, claim_clr;
  logic [PRIO_W-1:0]   prio [NUM_SRC];
  logic [PRIO_W-1:0]   best_prio;
  logic [ID_W-1:0]     best_id;
  logic                any_elig, latch, claim;
`ifdef IRQ_THRESHOLD_EN
  logic [PRIO_W-1:0]   threshold;
`endif

  always_comb begin
    elig = '0;
    claim_clr = '0;
    best_prio = '0;
    best_id = '0;
    any_elig = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
`ifdef IRQ_THRESHOLD_EN
      elig[i] = pending[i] & enable[i] & (prio[i] != '0) & (prio[i] > threshold);
`else
      elig[i] = pending[i] & enable[i] & (prio[i] != '0);
`endif
      // strict compare keeps the lowest index on equal priority
      if (elig[i] && (prio[i] > best_prio)) begin
        best_prio = prio[i];
        best_id = ID_W'(i);
        any_elig = 1'b1;
      end
      claim_clr[i] = claim & (irq_id == ID_W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    latch = 1'b0;
    claim = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_elig) begin
          latch = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (irq_ack) begin
          claim = 1'b1;
          state_d = SERVICE;
        end else if (!elig[irq_id]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (irq_done && (done_id == irq_id)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      irq_id <= '0;
      pc_save <= '0;
    end else begin
      state_q <= state_d;
      if (latch) irq_id <= best_id;
      if (claim) pc_save <= pc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending <= '0;
      prev <= '0;
      enable <= '0;
      for (int i = 0; i < NUM_SRC; i++) prio[i] <= '0;
`ifdef IRQ_THRESHOLD_EN
      threshold <= '0;
`endif
    end else begin
      prev <= irq_src;
      // a new edge in the claim cycle wins over the claim clear
      for (int i = 0; i < NUM_SRC; i++) begin
        if (EDGE_MASK[i]) pending[i] <= (pending[i] & ~claim_clr[i]) | (irq_src[i] & ~prev[i]);
        else              pending[i] <= irq_src[i];
      end
      if (en_we) enable <= en_wdata;
      if (prio_we && (int'(prio_idx) < NUM_SRC)) prio[prio_idx] <= prio_wdata;
`ifdef IRQ_THRESHOLD_EN
      if (thr_we) threshold <= thr_wdata;
`endif
    end
  end

  assign irq_req = (state_q == REQ);
  assign in_service = (state_q == SERVICE);
  assign pending_out = pending;

endmodule

// File: tb/tb_irq_controller_prio.sv
// tb/tb_irq_controller_prio.sv - scoreboard bench for irq_controller_prio
// Request IDs and claimed PCs are queued by stimulus and checked by a negedge monitor.
module tb_irq_controller_prio;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_src;
  logic        en_we;
  logic [7:0]  en_wdata;
  logic        prio_we;
  logic [2:0]  prio_idx;
  logic [2:0]  prio_wdata;
  logic [63:0] pc_in;
  logic        irq_ack;
  logic        irq_done;
  logic [2:0]  done_id;
`ifdef IRQ_THRESHOLD_EN
  logic        thr_we;
  logic [2:0]  thr_wdata;
`endif
  logic        irq_req;
  logic [2:0]  irq_id;
  logic [63:0] pc_save;
  logic        in_service;
  logic [7:0]  pending_out;

  int n_checks = 0;
  int n_pass = 0;
  logic [2:0]  id_q[$];
  logic [63:0] pc_q[$];
  logic        req_d = 1'b0;
  logic        svc_d = 1'b0;

  irq_controller_prio dut (
    .clk(clk), .reset(reset), .irq_src(irq_src),
    .en_we(en_we), .en_wdata(en_wdata),
    .prio_we(prio_we), .prio_idx(prio_idx), .prio_wdata(prio_wdata),
    .pc_in(pc_in), .irq_ack(irq_ack), .irq_done(irq_done), .done_id(done_id),
`ifdef IRQ_THRESHOLD_EN
    .thr_we(thr_we), .thr_wdata(thr_wdata),
`endif
    .irq_req(irq_req), .irq_id(irq_id), .pc_save(pc_save),
    .in_service(in_service), .pending_out(pending_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (irq_req && !req_d) begin
      if (id_q.size() == 0) chk("unexpected_req", 64'(irq_id), 64'hFFFF);
      else chk("req_id", 64'(irq_id), 64'(id_q.pop_front()));
    end
    if (in_service && !svc_d) begin
      if (pc_q.size() == 0) chk("unexpected_claim", pc_save, 64'hFFFF_FFFF);
      else chk("pc_save", pc_save, pc_q.pop_front());
    end
    req_d = irq_req;
    svc_d = in_service;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_prio(input logic [2:0] idx, input logic [2:0] p);
    prio_we = 1'b1; prio_idx = idx; prio_wdata = p;
    tick();
    prio_we = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (!irq_req && n < 20) begin
      tick();
      n++;
    end
    chk(nm, 64'(irq_req), 64'd1);
  endtask

  task automatic claim(input logic [63:0] pc);
    pc_q.push_back(pc);
    pc_in = pc; irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic complete(input logic [2:0] id);
    irq_done = 1'b1; done_id = id;
    tick();
    irq_done = 1'b0;
  endtask

  initial begin
    reset = 1'b0; irq_src = '0; en_we = 0; en_wdata = '0; prio_we = 0; prio_idx = '0;
    prio_wdata = '0; pc_in = '0; irq_ack = 0; irq_done = 0; done_id = '0;
`ifdef IRQ_THRESHOLD_EN
    thr_we = 0; thr_wdata = '0;
`endif
    tick(); tick();
    reset = 1'b1;
    chk("rst_req", 64'(irq_req), 0);
    chk("rst_id", 64'(irq_id), 0);
    chk("rst_pc", pc_save, 0);
    chk("rst_svc", 64'(in_service), 0);
    chk("rst_pend", 64'(pending_out), 0);

    // basic edge request, latency and claim
    en_we = 1'b1; en_wdata = 8'hFF; prio_we = 1'b1; prio_idx = 3'd3; prio_wdata = 3'd5;
    tick();
    en_we = 1'b0; prio_we = 1'b0;
    id_q.push_back(3'd3);
    irq_src = 8'h08;
    tick();
    irq_src = 8'h00;
    chk("lat_req_lo", 64'(irq_req), 0);
    chk("lat_pend", 64'(pending_out), 64'h08);
    tick();
    chk("lat_req_hi", 64'(irq_req), 1);
    claim(64'h1000);
    chk("claim_svc", 64'(in_service), 1);
    chk("claim_clr", 64'(pending_out[3]), 0);
    chk("claim_req_lo", 64'(irq_req), 0);
    complete(3'd3);
    chk("done3_svc", 64'(in_service), 0);

    // arbitration: 5 and 6 tie at 6, 1 at 4
    set_prio(3'd1, 3'd4);
    set_prio(3'd5, 3'd6);
    set_prio(3'd6, 3'd6);
    id_q.push_back(3'd5); id_q.push_back(3'd6); id_q.push_back(3'd1);
    irq_src = 8'h62;
    tick();
    irq_src = 8'h60;
    wait_req("arb_req5");
    claim(64'h2000);
    irq_src = 8'h40;
    tick();
    complete(3'd5);
    wait_req("arb_req6");
    claim(64'h3000);
    irq_src = 8'h00;
    tick();
    complete(3'd6);
    wait_req("arb_req1");
    claim(64'h4000);
    complete(3'd1);
    chk("arb_idle", 64'(irq_req), 0);

    // withdraw of a dropped level source, late ack ignored
    set_prio(3'd4, 3'd2);
    id_q.push_back(3'd4);
    irq_src = 8'h10;
    wait_req("wd_req");
    irq_src = 8'h00;
    tick();
    tick();
    chk("wd_req_lo", 64'(irq_req), 0);
    irq_ack = 1'b1; pc_in = 64'hDEAD;
    tick();
    irq_ack = 1'b0;
    chk("late_ack_svc", 64'(in_service), 0);
    chk("late_ack_pc", pc_save, 64'h4000);

    // mismatched done is ignored
    set_prio(3'd2, 3'd3);
    id_q.push_back(3'd2);
    irq_src = 8'h04;
    tick();
    irq_src = 8'h00;
    wait_req("hs_req");
    claim(64'h5000);
    complete(3'd3);
    chk("bad_done_svc", 64'(in_service), 1);
    complete(3'd2);
    chk("good_done_svc", 64'(in_service), 0);

    // reset in SERVICE clears everything; held source must not re-request
    set_prio(3'd7, 3'd7);
    id_q.push_back(3'd7);
    irq_src = 8'h80;
    wait_req("rs_req");
    claim(64'h6000);
    chk("rs_svc", 64'(in_service), 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rs_req_lo", 64'(irq_req), 0);
    chk("rs_svc_lo", 64'(in_service), 0);
    chk("rs_pend", 64'(pending_out), 0);
    chk("rs_pc", pc_save, 0);
    repeat (5) tick();
    chk("rs_no_req", 64'(irq_req), 0);
    chk("rs_no_svc", 64'(in_service), 0);
    irq_src = 8'h00;
    tick();

`ifdef IRQ_THRESHOLD_EN
    en_we = 1'b1; en_wdata = 8'hFF; thr_we = 1'b1; thr_wdata = 3'd4;
    prio_we = 1'b1; prio_idx = 3'd0; prio_wdata = 3'd4;
    tick();
    en_we = 1'b0; thr_we = 1'b0; prio_we = 1'b0;
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    repeat (4) tick();
    chk("thr_block", 64'(irq_req), 0);
    id_q.push_back(3'd0);
    set_prio(3'd0, 3'd5);
    wait_req("thr_req");
    chk("thr_id", 64'(irq_id), 0);
    claim(64'h7000);
    complete(3'd0);
`endif

    tick(); tick();
    chk("id_q_empty", 64'(id_q.size()), 0);
    chk("pc_q_empty", 64'(pc_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/irq_controller_prio.md
Name: irq_controller_prio

Overview:
- Parametrised multi-source interrupt controller; successor to the single-line request/acknowledge interrupt controller in riscv_processor_top.
- Collects NUM_SRC level- or edge-sensitive sources, masks them, and arbitrates by programmable per-source priority.
- Raises one request to the core with a source ID and runs a claim/complete handshake; captures the core PC at claim.

Parameters:
- NUM_SRC, 8, number of interrupt sources (2..32)
- PRIO_W, 3, priority field width; priority 0 = never interrupts
- XLEN, 64, PC width
- EDGE_MASK, 8'h0F, bit i = 1: source i edge-triggered (rising); 0: level-triggered (active-high)
- Derived localparam ID_W = $clog2(NUM_SRC)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset; reset=0 at a rising clk edge resets the block
- irq_src  in  NUM_SRC  raw interrupt sources, synchronous to clk
- en_we  in  1  write enable register
- en_wdata  in  NUM_SRC  new enable mask
- prio_we  in  1  write one priority entry
- prio_idx  in  ID_W  source index for priority write
- prio_wdata  in  PRIO_W  priority value
- pc_in  in  XLEN  current core PC
- irq_ack  in  1  core claims the current request
- irq_done  in  1  core completes service
- done_id  in  ID_W  ID being completed
- irq_req  out  1  interrupt request to core
- irq_id  out  ID_W  ID of requested / in-service source
- pc_save  out  XLEN  PC captured at claim
- in_service  out  1  a claimed interrupt is being serviced
- pending_out  out  NUM_SRC  pending vector, for debug

Behaviour:
- Reset (reset=0 at posedge): enable=0, all priorities=0, pending=0, edge history=0, state=IDLE, irq_req=0, irq_id=0, pc_save=0, in_service=0.
- Pending, edge sources:
  - Set when irq_src[i] & ~prev[i].
  - Cleared only at claim of i.
  - A rising edge in the claim cycle leaves pending set.
- Pending, level sources:
  - pending[i] is the registered value of irq_src[i].
  - Never cleared by claim.
- Eligibility: pending[i] & enable[i] & (prio[i] != 0).
- Arbitration: highest prio wins; on a tie, the lowest index wins. Combinational over the registered pending, enable and prio.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if any source is eligible, latch the winner into irq_id, set irq_req=1, go to REQ.
  - REQ:
    - irq_req is held and irq_id is frozen; a higher-priority arrival does not change irq_id.
    - If irq_ack=1: clear pending[irq_id] (edge sources only), pc_save<=pc_in, irq_req=0, in_service=1, go to SERVICE.
    - Else, if the latched source is no longer eligible (disabled, prio set to 0, or level dropped): withdraw. irq_req=0, go to IDLE; rearbitration happens the next cycle.
    - If ack and loss of eligibility occur in the same cycle, ack wins.
  - SERVICE:
    - irq_done=1 with done_id==irq_id: in_service=0, go to IDLE.
    - irq_done with a mismatched done_id is ignored.
    - Pending and config writes continue to update during SERVICE.
  - irq_ack outside REQ is ignored; irq_done outside SERVICE is ignored.
- Latency: source asserted before posedge k → pending at k → irq_req=1 after posedge k+1. Minimum 2 cycles from input to request. After done, the next request rises 1 cycle later.
- Config writes take effect at the next posedge. en_we and prio_we may occur in the same cycle. An out-of-range prio_idx (>=NUM_SRC) is ignored.
- A level source still asserted after done re-requests. This is intended; the handler must clear the device.

Optional Feature:
- Macro: IRQ_THRESHOLD_EN.
- With the macro defined:
  - Adds ports thr_we (in, 1) and thr_wdata (in, PRIO_W).
  - Adds a threshold register, reset to 0.
  - Eligibility additionally requires prio[i] > threshold.
  - A threshold rise while in REQ that makes irq_id ineligible causes a withdraw.
- Without the macro: no threshold ports or register; eligibility as above.

Test Plan:
- Reset → all outputs 0. Then enable=8'hFF, prio[3]=5, pulse irq_src[3] for 1 cycle → irq_req=1 and irq_id=3 two cycles after the pulse. Ack with pc_in=64'h1000 → pc_save=64'h1000, in_service=1, pending_out[3]=0.
- Arbitration: prio[1]=4, prio[5]=6, prio[6]=6; assert src 1, 5 and 6 in the same cycle → irq_id=5. After done(5) → irq_id=6; after done(6) → irq_id=1.
- Withdraw: level src 4, prio 2; request raised, then drop src 4 before ack → irq_req=0 the next cycle and FSM back in IDLE. A late ack has no effect (in_service stays 0).
- Handshake errors: in SERVICE with irq_id=2, irq_done with done_id=3 → in_service stays 1. done_id=2 → in_service=0.
- Reset mid-SERVICE: reset=0 for 1 cycle → irq_req, in_service, pending, enables and prio all 0. No request follows even with sources high.
- IRQ_THRESHOLD_EN: threshold=4; src 0 prio 4 asserted → no request; set prio[0]=5 → request with irq_id=0.
